// File: rtl/string_match_scheduler.sv
// Time-shares one string comparator across a table of flagged strings by
// capturing a packet once and replaying it for every enabled entry.
//
// state   | meaning
// IDLE    | waiting for the first packet word, table writable
// CAPTURE | storing packet words until pkt_end
// SELECT  | search for the next enabled entry at or above ptr
// CLEAR   | one-cycle comparator clear, entry[ptr] presented
// FEED    | replay buffered words, sample cmp_match
// DRAIN   | feed zero words, sample cmp_match
// DONE    | publish results, one-cycle done pulse
module string_match_scheduler #(
    parameter int NUM_STR   = 4,
    parameter int MAX_WORDS = 16,
    parameter int DRAIN     = 8,
    parameter int IDXW      = (NUM_STR > 1) ? $clog2(NUM_STR) : 1
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               cfg_wr,
    input  logic [IDXW-1:0]    cfg_idx,
    input  logic [135:0]       cfg_string,
    input  logic [4:0]         cfg_strlen,
    input  logic               cfg_en,
    output logic               cfg_err,
    input  logic               pkt_valid,
    input  logic [31:0]        pkt_data,
    input  logic               pkt_end,
    output logic               pkt_ready,
    output logic               cmp_clear,
    output logic [135:0]       cmp_flagged_string,
    output logic [4:0]         cmp_strlen,
    output logic [31:0]        cmp_data_in,
    input  logic               cmp_match,
    output logic               busy,
    output logic               done,
    output logic               hit,
    output logic [IDXW-1:0]    hit_idx,
    output logic [NUM_STR-1:0] hit_mask,
    output logic               overflow
);

    localparam int AW  = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
    localparam int WCW = $clog2(MAX_WORDS + 1);
    localparam int DCW = (DRAIN > 1) ? $clog2(DRAIN) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_CAPTURE, S_SELECT, S_CLEAR, S_FEED, S_DRAIN, S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [WCW-1:0]     wc_q, wc_d;
    logic [AW-1:0]      rd_q, rd_d;
    logic [DCW-1:0]     dc_q, dc_d;
    logic [IDXW-1:0]    ptr_q, ptr_d;
    logic [NUM_STR-1:0] acc_q, acc_d;
    logic               ovf_acc_q, ovf_acc_d;
    logic               hit_q, hit_d;
    logic [IDXW-1:0]    hit_idx_q, hit_idx_d;
    logic [NUM_STR-1:0] hit_mask_q, hit_mask_d;
    logic               overflow_q, overflow_d;
    logic               cfg_err_q, cfg_err_d;

    logic [135:0]       tbl_str_q [NUM_STR];
    logic [4:0]         tbl_len_q [NUM_STR];
    logic [NUM_STR-1:0] tbl_en_q;
    logic [31:0]        pkt_buf_q [MAX_WORDS];

    logic               cfg_ok, len_ok;
    logic               buf_we;
    logic [AW-1:0]      buf_waddr;
    logic               sel_found;
    logic [IDXW-1:0]    sel_idx;
    logic               active;

    assign cfg_ok = cfg_wr && (state_q == S_IDLE) && !pkt_valid;
    assign len_ok = (cfg_strlen != 5'd0) && (cfg_strlen <= 5'd17);

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = NUM_STR - 1; i >= 0; i--) begin
            if (tbl_en_q[i] && (IDXW'(i) >= ptr_q)) begin
                sel_found = 1'b1;
                sel_idx   = IDXW'(i);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        wc_d       = wc_q;
        rd_d       = rd_q;
        dc_d       = dc_q;
        ptr_d      = ptr_q;
        acc_d      = acc_q;
        ovf_acc_d  = ovf_acc_q;
        buf_we     = 1'b0;
        buf_waddr  = '0;
        cfg_err_d  = cfg_wr && !cfg_ok;
        case (state_q)
            S_IDLE: begin
                if (pkt_valid) begin
                    buf_we    = 1'b1;
                    wc_d      = WCW'(1);
                    acc_d     = '0;
                    ovf_acc_d = 1'b0;
                    ptr_d     = '0;
                    state_d   = pkt_end ? S_SELECT : S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (pkt_valid) begin
                    if (wc_q < WCW'(MAX_WORDS)) begin
                        buf_we    = 1'b1;
                        buf_waddr = wc_q[AW-1:0];
                        wc_d      = wc_q + 1'b1;
                    end else begin
                        ovf_acc_d = 1'b1;
                    end
                    if (pkt_end) state_d = S_SELECT;
                end
            end
            S_SELECT: begin
                if (sel_found) begin
                    ptr_d   = sel_idx;
                    state_d = S_CLEAR;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_CLEAR: begin
                rd_d    = '0;
                state_d = S_FEED;
            end
            S_FEED: begin
                if (cmp_match) acc_d[ptr_q] = 1'b1;
                if (WCW'(rd_q) == wc_q - WCW'(1)) begin
                    dc_d    = DCW'(DRAIN - 1);
                    state_d = S_DRAIN;
                end else begin
                    rd_d = rd_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (cmp_match) acc_d[ptr_q] = 1'b1;
                if (dc_q == '0) begin
                    // the top entry never wraps back to 0
                    if (ptr_q == IDXW'(NUM_STR - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        ptr_d   = ptr_q + 1'b1;
                        state_d = S_SELECT;
                    end
                end else begin
                    dc_d = dc_q - 1'b1;
                end
            end
            S_DONE: begin
                wc_d    = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Results are published on entry to DONE so they are valid alongside done.
    always_comb begin
        hit_d      = hit_q;
        hit_idx_d  = hit_idx_q;
        hit_mask_d = hit_mask_q;
        overflow_d = overflow_q;
        if ((state_d == S_DONE) && (state_q != S_DONE)) begin
            hit_d      = |acc_d;
            hit_mask_d = acc_d;
            overflow_d = ovf_acc_d;
            hit_idx_d  = '0;
            for (int i = NUM_STR - 1; i >= 0; i--) begin
                if (acc_d[i]) hit_idx_d = IDXW'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= S_IDLE;
            wc_q       <= '0;
            rd_q       <= '0;
            dc_q       <= '0;
            ptr_q      <= '0;
            acc_q      <= '0;
            ovf_acc_q  <= 1'b0;
            hit_q      <= 1'b0;
            hit_idx_q  <= '0;
            hit_mask_q <= '0;
            overflow_q <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wc_q       <= wc_d;
            rd_q       <= rd_d;
            dc_q       <= dc_d;
            ptr_q      <= ptr_d;
            acc_q      <= acc_d;
            ovf_acc_q  <= ovf_acc_d;
            hit_q      <= hit_d;
            hit_idx_q  <= hit_idx_d;
            hit_mask_q <= hit_mask_d;
            overflow_q <= overflow_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < NUM_STR; i++) begin
                tbl_str_q[i] <= '0;
                tbl_len_q[i] <= '0;
            end
            tbl_en_q <= '0;
        end else if (cfg_ok) begin
            tbl_str_q[cfg_idx] <= cfg_string;
            tbl_len_q[cfg_idx] <= cfg_strlen;
            tbl_en_q[cfg_idx]  <= cfg_en && len_ok;
        end
    end

    always_ff @(posedge clk) begin
        if (buf_we) pkt_buf_q[buf_waddr] <= pkt_data;
    end

    assign active             = (state_q == S_CLEAR) || (state_q == S_FEED) || (state_q == S_DRAIN);
    assign pkt_ready          = (state_q == S_IDLE) || (state_q == S_CAPTURE);
    assign busy               = (state_q != S_IDLE);
    assign done               = (state_q == S_DONE);
    assign cmp_clear          = (state_q == S_CLEAR);
    assign cmp_flagged_string = active ? tbl_str_q[ptr_q] : '0;
    assign cmp_strlen         = active ? tbl_len_q[ptr_q] : '0;
    assign cmp_data_in        = (state_q == S_FEED) ? pkt_buf_q[rd_q] : '0;
    assign cfg_err            = cfg_err_q;
    assign hit                = hit_q;
    assign hit_idx            = hit_idx_q;
    assign hit_mask           = hit_mask_q;
    assign overflow           = overflow_q;

endmodule

// File: tb/tb_string_match_scheduler.sv
// Directed bench for string_match_scheduler with a byte-stream comparator model
// driving cmp_match one cycle after the word that completes a string.
module tb_string_match_scheduler;

    logic         clk = 1'b0;
    logic         n_rst;
    logic         cfg_wr;
    logic [1:0]   cfg_idx;
    logic [135:0] cfg_string;
    logic [4:0]   cfg_strlen;
    logic         cfg_en;
    logic         cfg_err;
    logic         pkt_valid;
    logic [31:0]  pkt_data;
    logic         pkt_end;
    logic         pkt_ready;
    logic         cmp_clear;
    logic [135:0] cmp_flagged_string;
    logic [4:0]   cmp_strlen;
    logic [31:0]  cmp_data_in;
    logic         cmp_match;
    logic         busy;
    logic         done;
    logic         hit;
    logic [1:0]   hit_idx;
    logic [3:0]   hit_mask;
    logic         overflow;

    always #5 clk = ~clk;

    string_match_scheduler dut (
        .clk(clk), .n_rst(n_rst),
        .cfg_wr(cfg_wr), .cfg_idx(cfg_idx), .cfg_string(cfg_string),
        .cfg_strlen(cfg_strlen), .cfg_en(cfg_en), .cfg_err(cfg_err),
        .pkt_valid(pkt_valid), .pkt_data(pkt_data), .pkt_end(pkt_end),
        .pkt_ready(pkt_ready), .cmp_clear(cmp_clear),
        .cmp_flagged_string(cmp_flagged_string), .cmp_strlen(cmp_strlen),
        .cmp_data_in(cmp_data_in), .cmp_match(cmp_match),
        .busy(busy), .done(done), .hit(hit), .hit_idx(hit_idx),
        .hit_mask(hit_mask), .overflow(overflow)
    );

    // Comparator model: byte history since clear, newest byte lowest.
    logic [135:0] m_hist, nh;
    logic         m_match, hitany, ok;

    always_comb begin
        nh     = m_hist;
        hitany = 1'b0;
        ok     = 1'b0;
        for (int k = 0; k < 4; k++) begin
            nh = {nh[127:0], cmp_data_in[31-8*k -: 8]};
            ok = (cmp_strlen != 5'd0);
            for (int j = 0; j < 17; j++) begin
                if (j < int'(cmp_strlen)) begin
                    if (nh[8*(int'(cmp_strlen)-1-j) +: 8] != cmp_flagged_string[135-8*j -: 8]) ok = 1'b0;
                end
            end
            if (ok) hitany = 1'b1;
        end
    end

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            m_hist  <= '0;
            m_match <= 1'b0;
        end else if (cmp_clear) begin
            m_hist  <= '0;
            m_match <= 1'b0;
        end else begin
            m_hist  <= nh;
            m_match <= hitany;
        end
    end
    assign cmp_match = m_match;

    int cyc = 0, clr_cnt = 0, done_cnt = 0, last_clr_cyc = 0, clr_gap = 0;
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (cmp_clear) begin
            clr_cnt      <= clr_cnt + 1;
            clr_gap      <= cyc - last_clr_cyc;
            last_clr_cyc <= cyc;
        end
        if (done) done_cnt <= done_cnt + 1;
    end

    int checks = 0;
    int errors = 0;
    logic [31:0] pkt_w [0:31];

    typedef struct {
        logic [127:0] words;
        int           n;
        logic [3:0]   mask;
        logic [1:0]   idx;
    } vec_t;
    vec_t vecs [6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [135:0] mkstr(input logic [135:0] s, input int len);
        return s << (8 * (17 - len));
    endfunction

    function automatic int lat_of(input int en, input int wc);
        return (en + 1) + en * (9 + wc) + 1;
    endfunction

    task automatic cfg_write(input int idx, input logic [135:0] s, input int len,
                             input logic en, input logic exp_err, input string name);
        cfg_wr     = 1'b1;
        cfg_idx    = 2'(idx);
        cfg_string = s;
        cfg_strlen = 5'(len);
        cfg_en     = en;
        tick;
        cfg_wr = 1'b0;
        chk(name, cfg_err, exp_err);
    endtask

    task automatic send_pkt(input int n);
        for (int i = 0; i < n; i++) begin
            pkt_valid = 1'b1;
            pkt_data  = pkt_w[i];
            pkt_end   = (i == n - 1);
            tick;
        end
        pkt_valid = 1'b0;
        pkt_end   = 1'b0;
        pkt_data  = '0;
    endtask

    task automatic wait_done(output int lat);
        lat = 1;
        while (done !== 1'b1 && lat < 2000) begin
            tick;
            lat++;
        end
        if (done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: no done after %0d cycles", lat);
        end
    endtask

    task automatic wait_clear(input string name);
        int k;
        k = 0;
        while (cmp_clear !== 1'b1 && k < 100) begin
            tick;
            k++;
        end
        chk(name, cmp_clear, 1'b1);
    endtask

    task automatic run_check(input string name, input int n, input logic [3:0] mask,
                             input logic [1:0] idx, input logic ovf,
                             input int exp_clr, input int exp_lat);
        int c0, lat;
        c0 = clr_cnt;
        send_pkt(n);
        wait_done(lat);
        chk({name, "_lat"}, lat, exp_lat);
        chk({name, "_hit"}, hit, |mask);
        chk({name, "_idx"}, hit_idx, idx);
        chk({name, "_mask"}, hit_mask, mask);
        chk({name, "_ovf"}, overflow, ovf);
        chk({name, "_clears"}, clr_cnt - c0, exp_clr);
        tick;
        chk({name, "_done_pulse"}, {done, busy}, 2'b00);
        chk({name, "_mask_held"}, hit_mask, mask);
    endtask

    initial begin
        int lat, c0, d0;
        vecs[0] = '{{"    ", "abc ", 64'h0}, 2, 4'b0101, 2'd0};
        vecs[1] = '{{"xyz ", "    ", 64'h0}, 2, 4'b0010, 2'd1};
        vecs[2] = '{{"zzab", "c   ", 64'h0}, 2, 4'b0101, 2'd0};
        vecs[3] = '{{"qqqq", 96'h0},         1, 4'b0000, 2'd0};
        vecs[4] = '{{"ab x", "yz  ", 64'h0}, 2, 4'b0010, 2'd1};
        vecs[5] = '{{"xyza", "bc  ", 64'h0}, 2, 4'b0111, 2'd0};

        n_rst = 1'b0; cfg_wr = 1'b0; cfg_idx = '0; cfg_string = '0;
        cfg_strlen = '0; cfg_en = 1'b0; pkt_valid = 1'b0; pkt_data = '0; pkt_end = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy_done", {busy, done, cmp_clear, cfg_err}, 4'b0000);
        chk("rst_results", {hit, hit_idx, hit_mask, overflow}, 8'h00);
        chk("rst_cmp", {cmp_data_in, 27'h0, cmp_strlen, |cmp_flagged_string}, 64'h0);
        n_rst = 1'b1;
        tick;
        chk("rst_ready", pkt_ready, 1'b1);

        pkt_w[0] = 32'h1234_5678; pkt_w[1] = "abc ";
        run_check("empty", 2, 4'b0000, 2'd0, 1'b0, 0, 2);

        cfg_write(0, mkstr("www.google.com", 14), 14, 1'b1, 1'b0, "cfg_google");
        pkt_w[0] = "www."; pkt_w[1] = "goog"; pkt_w[2] = "le.c";
        pkt_w[3] = "om  "; pkt_w[4] = "    ";
        run_check("google", 5, 4'b0001, 2'd0, 1'b0, 1, 17);

        cfg_write(0, mkstr("abc", 3), 3, 1'b1, 1'b0, "cfg_e0");
        cfg_write(1, mkstr("xyz", 3), 3, 1'b1, 1'b0, "cfg_e1");
        cfg_write(2, mkstr("abc", 3), 3, 1'b1, 1'b0, "cfg_e2");
        cfg_write(3, mkstr("abc", 3), 3, 1'b0, 1'b0, "cfg_e3");
        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < vecs[v].n; i++) pkt_w[i] = vecs[v].words[127-32*i -: 32];
            run_check($sformatf("vec%0d", v), vecs[v].n, vecs[v].mask, vecs[v].idx,
                      1'b0, 3, lat_of(3, vecs[v].n));
        end

        for (int i = 0; i < 15; i++) pkt_w[i] = "    ";
        pkt_w[15] = "xyz "; pkt_w[16] = "abc "; pkt_w[17] = "abc ";
        run_check("ovf", 18, 4'b0010, 2'd1, 1'b1, 3, lat_of(3, 16));
        chk("ovf_entry_period", clr_gap, 26);

        // Config write and a packet word both arrive while the entry is being fed.
        pkt_w[0] = "abc ";
        c0 = clr_cnt;
        send_pkt(1);
        wait_clear("lock_clear_seen");
        tick;
        cfg_wr = 1'b1; cfg_idx = 2'd1; cfg_string = mkstr("abc", 3); cfg_strlen = 5'd3; cfg_en = 1'b1;
        pkt_valid = 1'b1; pkt_data = "xyz "; pkt_end = 1'b1;
        chk("lock_ready_busy", {pkt_ready, busy}, 2'b01);
        tick;
        cfg_wr = 1'b0; pkt_valid = 1'b0; pkt_end = 1'b0; pkt_data = '0;
        chk("lock_cfg_err", cfg_err, 1'b1);
        tick;
        chk("lock_err_pulse", cfg_err, 1'b0);
        wait_done(lat);
        chk("lock_mask", hit_mask, 4'b0101);
        chk("lock_ovf_cleared", overflow, 1'b0);
        chk("lock_clears", clr_cnt - c0, 3);
        tick;

        cfg_wr = 1'b1; cfg_idx = 2'd1; cfg_string = mkstr("abc", 3); cfg_strlen = 5'd3; cfg_en = 1'b1;
        pkt_valid = 1'b1; pkt_data = "xyz "; pkt_end = 1'b1;
        tick;
        cfg_wr = 1'b0; pkt_valid = 1'b0; pkt_end = 1'b0; pkt_data = '0;
        chk("collide_cfg_err", cfg_err, 1'b1);
        wait_done(lat);
        chk("collide_lat", lat, lat_of(3, 1));
        chk("collide_mask", hit_mask, 4'b0010);
        tick;

        cfg_write(1, mkstr("xyz", 3), 18, 1'b1, 1'b0, "cfg_len18");
        pkt_w[0] = "xyz ";
        run_check("len18", 1, 4'b0000, 2'd0, 1'b0, 2, lat_of(2, 1));

        pkt_w[0] = "    "; pkt_w[1] = "abc ";
        send_pkt(2);
        wait_clear("midrst_clear_seen");
        tick;
        d0 = done_cnt;
        #2 n_rst = 1'b0;
        #1;
        chk("midrst_ctrl", {busy, done, cmp_clear, cfg_err}, 4'b0000);
        chk("midrst_results", {hit, hit_idx, hit_mask, overflow}, 8'h00);
        chk("midrst_cmp", {cmp_data_in, 27'h0, cmp_strlen, |cmp_flagged_string}, 64'h0);
        repeat (3) tick;
        chk("midrst_no_done", done_cnt - d0, 0);
        n_rst = 1'b1;
        tick;
        chk("midrst_ready", {pkt_ready, busy}, 2'b10);
        run_check("post_rst", 2, 4'b0000, 2'd0, 1'b0, 0, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
